// File: rtl/stream_pkg.sv
// ============================================================================
// Module   : stream_pkg
// Purpose  : Shared definitions for the lock-in / mixer stream chain
//            (multiplier, boxcar decimator and downstream stages).
// Contents : DEFAULT_DATA_WIDTH  - default sample width, Q1.(W-1) signed
//            acc_width()         - accumulator width for a 2^L-sample sum
//            clamp_log2()        - clamps a requested log2 window length
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // A sum of 2^MAX_LOG2_N samples of DATA_WIDTH bits needs MAX_LOG2_N extra
  // integer bits to be overflow-free.
  function automatic int acc_width(input int data_width, input int max_log2_n);
    return data_width + max_log2_n;
  endfunction

  // Requests above the supported maximum saturate at the maximum.
  function automatic logic [7:0] clamp_log2(input logic [7:0] req, input int max_l);
    if (int'(req) > max_l) begin
      return 8'(max_l);
    end
    return req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_boxcar_decimator.sv
// ============================================================================
// Module   : stream_boxcar_decimator
// Purpose  : Boxcar averager + decimator. Sums 2^L accepted signed samples
//            and emits their mean (arithmetic shift) once per window.
// Ports    : clk            - clock, rising edge
//            resetn         - synchronous active-low reset
//            clear          - synchronous window restart, drops partial sum
//            decim_log2     - requested L (window N = 2^L), clamped
//            data_i_tdata   - signed input sample
//            data_i_tvalid  - input sample accepted when high (no backpressure)
//            data_o_tdata   - registered signed window mean
//            data_o_tvalid  - one-cycle pulse per completed window
//            window_l       - L currently in effect
// Config   : STREAM_BOXCAR_ROUND_EN - when defined, adds 2^(L-1) before the
//            shift (round half up); otherwise the mean is floored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_boxcar_decimator
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_LOG2_N = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [7:0]            decim_log2,
  input  logic [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                  data_i_tvalid,
  output logic [DATA_WIDTH-1:0] data_o_tdata,
  output logic                  data_o_tvalid,
  output logic [7:0]            window_l
);

  localparam int c_ACC_W = acc_width(DATA_WIDTH, MAX_LOG2_N);
  localparam int c_CNT_W = MAX_LOG2_N + 1;

  logic signed [c_ACC_W-1:0] r_acc;
  logic        [c_CNT_W-1:0] r_cnt;
  logic        [7:0]         r_l_act;

  logic                      w_empty;
  logic        [7:0]         w_l_req;
  logic        [7:0]         w_l;
  logic        [c_CNT_W-1:0] w_cnt_max;
  logic                      w_last;
  logic signed [c_ACC_W-1:0] w_ext;
  logic signed [c_ACC_W-1:0] w_sum;
  logic signed [c_ACC_W-1:0] w_rsum;
  logic signed [c_ACC_W-1:0] w_shifted;

  assign w_empty = (r_cnt == '0);
  assign w_l_req = clamp_log2(decim_log2, MAX_LOG2_N);

  // The first sample of a window must already see the newly latched L, so
  // the effective L bypasses the register while the window is empty.
  assign w_l = w_empty ? w_l_req : r_l_act;

  assign w_cnt_max = (c_CNT_W'(1) << w_l) - c_CNT_W'(1);
  assign w_last    = (r_cnt == w_cnt_max);

  assign w_ext = {{MAX_LOG2_N{data_i_tdata[DATA_WIDTH-1]}}, data_i_tdata};
  assign w_sum = r_acc + w_ext;

`ifdef STREAM_BOXCAR_ROUND_EN
  logic signed [c_ACC_W-1:0] w_bias;
  // Half an LSB of the output; absent for L=0 so pass-through is exact.
  assign w_bias = (w_l == 8'd0) ? '0 : (c_ACC_W'(1) << (w_l - 8'd1));
  assign w_rsum = w_sum + w_bias;
`else
  assign w_rsum = w_sum;
`endif

  // Arithmetic shift floors toward minus infinity; the mean of in-range
  // samples always fits DATA_WIDTH so plain truncation is safe.
  assign w_shifted = w_rsum >>> w_l;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      r_l_act       <= '0;
      data_o_tdata  <= '0;
      data_o_tvalid <= 1'b0;
    end else begin
      data_o_tvalid <= 1'b0;
      if (w_empty) begin
        r_l_act <= w_l_req;
      end
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (data_i_tvalid) begin
        if (w_last) begin
          data_o_tdata  <= DATA_WIDTH'(w_shifted);
          data_o_tvalid <= 1'b1;
          r_acc         <= '0;
          r_cnt         <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign window_l = r_l_act;

endmodule

`default_nettype wire

// File: doc/stream_boxcar_decimator.md
# stream_boxcar_decimator

Boxcar averager and decimator for signed fixed-point sample streams. It sits directly downstream of `stream_multiplier` in the lock-in/mixer chain. It consumes the Q1.(DATA_WIDTH-1) product stream, sums 2^L accepted samples, and emits their mean as one output sample per window. This gives a low-pass-filtered, rate-reduced stream.

## Interface
- `DATA_WIDTH`, 16, width of input and output samples, signed two's complement.
- `MAX_LOG2_N`, 10, largest supported log2 of the window length. Sets the accumulator width to DATA_WIDTH+MAX_LOG2_N.
- `clk` input 1: clock; everything is on the rising edge.
- `resetn` input 1: reset, synchronous, active-low; clock `clk`.
- `clear` input 1: synchronous window restart; discards the partial sum.
- `decim_log2` input 8: requested L (window length N = 2^L), unsigned.
- `data_i_tdata` input DATA_WIDTH: signed input sample.
- `data_i_tvalid` input 1: sample is accepted on every cycle this is high. There is no backpressure.
- `data_o_tdata` output DATA_WIDTH: signed window mean, registered.
- `data_o_tvalid` output 1: high for exactly one cycle per completed window.
- `window_l` output 8: L currently in effect, for status readback.

## Operation
- State registers:
  - accumulator `acc`, signed, DATA_WIDTH+MAX_LOG2_N bits;
  - sample counter `cnt`, MAX_LOG2_N+1 bits;
  - active shift `l_act`.
- Reset values: acc=0, cnt=0, l_act=0, data_o_tdata=0, data_o_tvalid=0, window_l=0.
- Two phases, decoded from `cnt`:
  - EMPTY (cnt==0): while in EMPTY, l_act <= min(decim_log2, MAX_LOG2_N) every cycle. A value of decim_log2 greater than MAX_LOG2_N is clamped.
  - FILL (cnt>0): l_act is frozen. A change on decim_log2 mid-window takes effect only at the next window.
- The first sample of a window uses the L latched in that same cycle. It is computed combinationally from decim_log2 when cnt==0.
- Per accepted sample (data_i_tvalid=1, clear=0), with sum = acc + sign_extend(data_i_tdata):
  - If cnt == 2^L - 1: data_o_tdata <= sum >>> L, truncated to DATA_WIDTH; data_o_tvalid <= 1; acc <= 0; cnt <= 0.
  - Else: acc <= sum; cnt <= cnt+1.
- Arithmetic:
  - Shift is arithmetic, so the result rounds toward minus infinity.
  - The mean of N in-range samples always fits in DATA_WIDTH, so no saturation is needed.
  - The accumulator cannot overflow for L ≤ MAX_LOG2_N.
- L=0: pass-through with one cycle of latency; every valid input produces an output.
- clear=1: acc <= 0, cnt <= 0, data_o_tvalid <= 0.
  - If data_i_tvalid is high in the same cycle, clear wins and that sample is dropped.
  - data_o_tdata holds its last value.
- Cycles with data_i_tvalid=0 leave acc and cnt unchanged. Gaps do not affect the result.
- resetn low mid-window: all state returns to reset values on that edge. The partial sum is lost.
- `window_l` mirrors l_act.

## Timing
- Latency: the output is registered one cycle after the edge that accepts the final sample of a window.
- data_o_tvalid is a single-cycle pulse.
- Maximum output rate: one sample per cycle (L=0). Otherwise one per 2^L accepted inputs.
- data_o_tdata is stable from each tvalid pulse until the next pulse, clear, or reset.
- There is exactly one adder plus one barrel shift in the critical path. Both are registered at the output.

## Configuration
- `STREAM_BOXCAR_ROUND_EN`:
  - Defined: when L>0, the constant 2^(L-1) is added to sum before the shift. This gives round-half-up toward plus infinity. The bias adder is compiled in.
  - Undefined: plain arithmetic shift (floor), with no extra adder.
  - L=0 is identical in both cases.

## Structure
- Shared package `stream_pkg`:
  - default DATA_WIDTH;
  - an `acc_width(DATA_WIDTH, MAX_LOG2_N)` constant function;
  - the clamp helper for the log2 value.
  - Multiplier and downstream stages use the same package.
- Single module. No sub-module is warranted: the counter, accumulator and shifter are tightly coupled and small.

## Test plan
- L=2, continuous valid, inputs 100,200,300,400 → one pulse, data_o_tdata=250, one cycle after the 4th sample.
- Same four samples with random 0–3 cycle valid gaps → identical single output 250, no extra pulses.
- L=1, inputs -3,-4 → -4 without macro; -3 with STREAM_BOXCAR_ROUND_EN.
- Full scale:
  - L=10, 1024 × -32768 → -32768.
  - L=10, 1024 × 32767 → 32767.
  - No wrap in either case.
- L=2: feed 1000,1000, then clear together with valid sample 9, then 4,4,4,4 → single output 4. The dropped sample is not counted.
- Config and reset mid-window:
  - L=2: after 2 samples, change decim_log2 to 0; remaining 2 samples still close a 4-sample window. The following inputs then pass through one per cycle, and window_l reads 0.
  - Assert resetn low mid-window → all outputs 0 on the next edge.
